y_diag_update_seq: RTL and testbench
====================================

// Module: y_diag_update_seq
// PURPOSE
// - Sequencer + accumulator for one node's change-in-Y diagonal: Ynew_diag = Ydiag - sum(y_old_k) + sum(y_new_k), k = branches of the node.
// - Sits in the change-in-Y integration path. Takes a node's diagonal plus a valid/ready stream of branch (old,new) admittance pairs. Emits the updated diagonal to the Y-matrix writeback.
// PARAMETERS
// - WIDTH   48  complex word; [WIDTH-1:WIDTH/2] = real, [WIDTH/2-1:0] = imag, each two's complement
// - MAX_BR  8   max branches accepted per node; the next non-last branch after that is an error
// - CNT_W   4   width of br_count; must hold MAX_BR
// PORTS
// - clock        in   1       rising-edge clock
// - reset        in   1       synchronous, active-high
// - start        in   1       begin a node; accepted when start & start_ready
// - start_no_br  in   1       qualifies start: node has zero branch changes
// - y_diag_in    in   WIDTH   current diagonal, sampled on start acceptance
// - start_ready  out  1       high only in IDLE
// - br_valid     in   1       branch pair valid
// - br_ready     out  1       high only in FETCH
// - br_y_old     in   WIDTH   admittance being removed
// - br_y_new     in   WIDTH   admittance being inserted
// - br_last      in   1       marks final branch of the node
// - y_out        out  WIDTH   updated diagonal (accumulator register)
// - y_out_valid  out  1       high only in DONE
// - y_out_ready  in   1       consumer accepts y_out
// - br_count     out  CNT_W   branches consumed for current node
// - ovf          out  1       sticky per node: any real/imag lane signed overflow
// - err_too_many out  1       sticky per node: MAX_BR reached without br_last
// BEHAVIOUR
// - Reset (sync, takes priority over all): state=IDLE; acc, branch regs, br_count, ovf, err_too_many = 0.
//   Hence y_out=0, y_out_valid=0, br_ready=0, start_ready=1 in the first cycle after reset.
// - Reset mid-node: the partial sum is discarded. No output is produced for that node.
// - FSM IDLE->FETCH->SUB->ADD->(FETCH | DONE)->IDLE.
// - IDLE: on start, acc<=y_diag_in; br_count, ovf, err_too_many <= 0.
//   Next state is DONE if start_no_br, else FETCH.
// - FETCH: on br_valid, capture old, new and last into regs; br_count++; go to SUB. With no br_valid, stay in FETCH (no timeout).
// - SUB: acc <= acc - old_r, lane-wise. ADD: acc <= acc + new_r, lane-wise.
// - ADD exit: go to DONE if last_r, or if br_count==MAX_BR (this case also sets err_too_many). Otherwise go to FETCH.
// - DONE: y_out_valid=1 and y_out is held stable. On y_out_ready, go to IDLE.
//   A start in that same cycle is not accepted, because start_ready=0.
// - Arithmetic: real and imag lanes are WIDTH/2 bits each, wrap modulo 2^(WIDTH/2), with no carry between lanes.
//   Signed overflow in either lane sets ovf; ovf is cleared only on the next start.
// - Latency, br_valid held high: start accepted at t0 -> y_out_valid at t0+1+3N (N branches); t0+1 when start_no_br.
// - Throughput: 3 cycles per branch, plus 2 cycles of node overhead (IDLE, DONE).
// - Handshakes: a transfer occurs only on valid & ready. Inputs may change freely when not being sampled.
// STRUCTURE
// - Shared package y_pkg: WIDTH and half-width localparams, real/imag slice functions, FSM state enum.
//   Other change-in-Y blocks use the same package.
// - One sub-module, reused: addsub_cplx (lane-wise complex add/sub, mode 0=add, 1=sub), driven by the FSM.
//   It is extended with a per-lane overflow output. Everything else stays in this file.
// TESTING
// - Reset, then start with y_diag=(100,-50) and one pair old=(10,5), new=(30,-5), last=1.
//   -> y_out=(120,-60) at t0+4; ovf=0; br_count=1.
// - start_no_br=1, y_diag=(7,7) -> y_out_valid at t0+1 with y_out=(7,7); br_ready is never asserted.
// - Three branches with br_valid gapped 2 cycles each: old=(1,1)x3, new=(2,0)x3, y_diag=0 -> y_out=(3,-3).
//   Check br_ready=0 outside FETCH.
// - Overflow: y_diag=(0x7FFFFF,0), one branch old=0, new=(1,0) -> y_out real=0x800000; ovf=1.
//   The next node clears ovf.
// - Nine branches with no br_last, MAX_BR=8 -> DONE after the 8th; err_too_many=1; br_count=8; the 9th branch is not accepted.
// - Hold y_out_ready=0 for 5 cycles in DONE -> y_out stable; a start then is ignored.
//   Assert reset during SUB on the next node -> IDLE next cycle, and all outputs return to reset values.

Source files
------------

// File: rtl/y_pkg.sv
// Shared change-in-Y definitions: complex word layout, lane helpers and sequencer states.
package y_pkg;

  localparam int unsigned WIDTH  = 48;
  localparam int unsigned HALF_W = WIDTH / 2;

  typedef struct packed {
    logic [HALF_W-1:0] re;
    logic [HALF_W-1:0] im;
  } cplx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SUB,
    ST_ADD,
    ST_DONE
  } y_state_e;

  function automatic logic [HALF_W-1:0] cplx_re(input logic [WIDTH-1:0] v);
    return v[WIDTH-1:HALF_W];
  endfunction

  function automatic logic [HALF_W-1:0] cplx_im(input logic [WIDTH-1:0] v);
    return v[HALF_W-1:0];
  endfunction

endpackage

// File: rtl/addsub_cplx.sv
// Lane-wise complex add/subtract (mode 0=add, 1=sub) with per-lane signed overflow flags.
module addsub_cplx
  import y_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic [WIDTH-1:0] y_c,
  output logic             ovf_re_c,
  output logic             ovf_im_c
);

  cplx_t a_s, b_s, y_s;

  // Overflow: operands effectively share a sign but the result's sign differs.
  function automatic logic lane_ovf(input logic xs, input logic zs, input logic rs,
                                    input logic sub);
    return (sub ? (xs != zs) : (xs == zs)) && (rs != xs);
  endfunction

  assign a_s = cplx_t'(a);
  assign b_s = cplx_t'(b);

  always_comb begin
    y_s.re   = mode ? (a_s.re - b_s.re) : (a_s.re + b_s.re);
    y_s.im   = mode ? (a_s.im - b_s.im) : (a_s.im + b_s.im);
    ovf_re_c = lane_ovf(a_s.re[HALF_W-1], b_s.re[HALF_W-1], y_s.re[HALF_W-1], mode);
    ovf_im_c = lane_ovf(a_s.im[HALF_W-1], b_s.im[HALF_W-1], y_s.im[HALF_W-1], mode);
  end

  assign y_c = WIDTH'(y_s);

endmodule

// File: rtl/y_diag_update_seq.sv
// Sequences one node's branch (old,new) pairs and accumulates Ydiag - sum(old) + sum(new).
module y_diag_update_seq
  import y_pkg::*;
#(
  parameter int unsigned MAX_BR = 8,
  parameter int unsigned CNT_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             start_no_br,
  input  logic [WIDTH-1:0] y_diag_in,
  output logic             start_ready,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [WIDTH-1:0] br_y_old,
  input  logic [WIDTH-1:0] br_y_new,
  input  logic             br_last,
  output logic [WIDTH-1:0] y_out,
  output logic             y_out_valid,
  input  logic             y_out_ready,
  output logic [CNT_W-1:0] br_count,
  output logic             ovf,
  output logic             err_too_many
);

  y_state_e         state_q, state_d;
  logic [WIDTH-1:0] old_q, new_q;
  logic             last_q;
  logic             at_max_c;
  logic             too_many_c;
  logic             as_mode_c;
  logic [WIDTH-1:0] as_b_c, as_y_c;
  logic             as_ovf_re_c, as_ovf_im_c;

  // One shared add/sub unit: subtracts old in SUB, adds new in ADD.
  addsub_cplx u_addsub (
    .a        (y_out),
    .b        (as_b_c),
    .mode     (as_mode_c),
    .y_c      (as_y_c),
    .ovf_re_c (as_ovf_re_c),
    .ovf_im_c (as_ovf_im_c)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    at_max_c   = (br_count == CNT_W'(MAX_BR));
    too_many_c = 1'b0;
    as_mode_c  = (state_q == ST_SUB);
    as_b_c     = as_mode_c ? old_q : new_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = start_no_br ? ST_DONE : ST_FETCH;
      ST_FETCH: if (br_valid) state_d = ST_SUB;
      ST_SUB:   state_d = ST_ADD;
      ST_ADD: begin
        too_many_c = at_max_c && !last_q;
        state_d    = (last_q || at_max_c) ? ST_DONE : ST_FETCH;
      end
      ST_DONE:  if (y_out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Handshake flags track the state being entered so they line up with state_q.
  always_ff @(posedge clock) begin
    if (reset) begin
      start_ready <= 1'b1;
      br_ready    <= 1'b0;
      y_out_valid <= 1'b0;
    end else begin
      start_ready <= (state_d == ST_IDLE);
      br_ready    <= (state_d == ST_FETCH);
      y_out_valid <= (state_d == ST_DONE);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      y_out        <= '0;
      old_q        <= '0;
      new_q        <= '0;
      last_q       <= 1'b0;
      br_count     <= '0;
      ovf          <= 1'b0;
      err_too_many <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            y_out        <= y_diag_in;
            br_count     <= '0;
            ovf          <= 1'b0;
            err_too_many <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (br_valid) begin
            old_q    <= br_y_old;
            new_q    <= br_y_new;
            last_q   <= br_last;
            br_count <= br_count + CNT_W'(1);
          end
        end
        ST_SUB, ST_ADD: begin
          y_out <= as_y_c;
          if (as_ovf_re_c || as_ovf_im_c) ovf <= 1'b1;
          if (too_many_c) err_too_many <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_y_diag_update_seq.sv
// Randomized bench for y_diag_update_seq against an integer-arithmetic reference of the diagonal update.
module tb_y_diag_update_seq;
  import y_pkg::*;

  localparam int unsigned MAX_BR = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int          LIMIT  = 200;

  logic             clock = 1'b0;
  logic             reset;
  logic             start, start_no_br;
  logic [WIDTH-1:0] y_diag_in;
  logic             start_ready;
  logic             br_valid, br_ready;
  logic [WIDTH-1:0] br_y_old, br_y_new;
  logic             br_last;
  logic [WIDTH-1:0] y_out;
  logic             y_out_valid, y_out_ready;
  logic [CNT_W-1:0] br_count;
  logic             ovf, err_too_many;

  always #5 clock = ~clock;

  y_diag_update_seq #(.MAX_BR(MAX_BR), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .start_no_br  (start_no_br),
    .y_diag_in    (y_diag_in),
    .start_ready  (start_ready),
    .br_valid     (br_valid),
    .br_ready     (br_ready),
    .br_y_old     (br_y_old),
    .br_y_new     (br_y_new),
    .br_last      (br_last),
    .y_out        (y_out),
    .y_out_valid  (y_out_valid),
    .y_out_ready  (y_out_ready),
    .br_count     (br_count),
    .ovf          (ovf),
    .err_too_many (err_too_many)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] b_old [16];
  logic [WIDTH-1:0] b_new [16];
  logic             b_last[16];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] mk(input int re, input int im);
    return {HALF_W'(re), HALF_W'(im)};
  endfunction

  function automatic longint sx(input logic [HALF_W-1:0] v);
    return longint'($signed(v));
  endfunction

  // One lane operation on true integers; out-of-range flags overflow, then wrap to the lane width.
  function automatic longint lane_step(input longint a, input longint b, input bit sub,
                                       inout logic o);
    longint r, lim;
    logic [HALF_W-1:0] t;
    lim = longint'(1) << (HALF_W - 1);
    r = sub ? (a - b) : (a + b);
    if (r >= lim || r < -lim) o = 1'b1;
    t = HALF_W'(r);
    return sx(t);
  endfunction

  function automatic void model(input logic [WIDTH-1:0] diag, input int n,
                                output logic [WIDTH-1:0] y, output logic o,
                                output logic e, output int cnt);
    longint re, im;
    re = sx(cplx_re(diag));
    im = sx(cplx_im(diag));
    o = 1'b0; e = 1'b0; cnt = 0;
    for (int i = 0; i < n; i++) begin
      re = lane_step(re, sx(cplx_re(b_old[i])), 1'b1, o);
      im = lane_step(im, sx(cplx_im(b_old[i])), 1'b1, o);
      re = lane_step(re, sx(cplx_re(b_new[i])), 1'b0, o);
      im = lane_step(im, sx(cplx_im(b_new[i])), 1'b0, o);
      cnt++;
      if (b_last[i]) break;
      if (cnt == int'(MAX_BR)) begin
        e = 1'b1;
        break;
      end
    end
    y = {HALF_W'(re), HALF_W'(im)};
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".y_out"},        64'(y_out),        64'(0));
    chk({tag, ".y_out_valid"},  64'(y_out_valid),  64'(0));
    chk({tag, ".br_ready"},     64'(br_ready),     64'(0));
    chk({tag, ".start_ready"},  64'(start_ready),  64'(1));
    chk({tag, ".br_count"},     64'(br_count),     64'(0));
    chk({tag, ".ovf"},          64'(ovf),          64'(0));
    chk({tag, ".err_too_many"}, 64'(err_too_many), 64'(0));
  endtask

  // Runs one node from IDLE to IDLE; ends at a falling edge with the DUT back in IDLE.
  task automatic run_node(input string tag, input logic [WIDTH-1:0] diag, input int n,
                          input int gap, input int hold);
    logic [WIDTH-1:0] ey, held;
    logic eo, ee;
    int ecnt, cyc, bi, gapc;
    bit will;
    model(diag, n, ey, eo, ee, ecnt);
    chk({tag, ".idle_ready"}, 64'(start_ready), 64'(1));
    start = 1'b1; start_no_br = (n == 0); y_diag_in = diag;
    @(negedge clock);
    start = 1'b0; start_no_br = 1'($urandom); y_diag_in = WIDTH'({$urandom, $urandom});
    cyc = 0; bi = 0; gapc = gap;
    while (!y_out_valid && cyc < LIMIT) begin
      chk({tag, ".no_ready_in_idle"}, 64'(br_ready && start_ready), 64'(0));
      if (!br_valid && bi < n) begin
        if (gapc > 0) gapc--;
        else begin
          br_valid = 1'b1; br_y_old = b_old[bi]; br_y_new = b_new[bi]; br_last = b_last[bi];
        end
      end
      will = br_valid && br_ready;
      @(negedge clock);
      cyc++;
      if (will) begin
        bi++;
        br_valid = 1'b0;
        br_y_old = WIDTH'({$urandom, $urandom});
        gapc = gap;
        chk({tag, ".ready_low_in_sub"}, 64'(br_ready), 64'(0));
      end
    end
    br_valid = 1'b0;
    chk({tag, ".valid"},    64'(y_out_valid), 64'(1));
    chk({tag, ".accepted"}, 64'(bi),          64'(ecnt));
    if (gap == 0) chk({tag, ".latency"}, 64'(cyc), 64'(3 * ecnt));
    chk({tag, ".done_br_ready"},    64'(br_ready),     64'(0));
    chk({tag, ".done_start_ready"}, 64'(start_ready),  64'(0));
    chk({tag, ".y_out"},            64'(y_out),        64'(ey));
    chk({tag, ".ovf"},              64'(ovf),          64'(eo));
    chk({tag, ".err_too_many"},     64'(err_too_many), 64'(ee));
    chk({tag, ".br_count"},         64'(br_count),     64'(ecnt));
    held = y_out;
    for (int k = 0; k < hold; k++) begin
      start = 1'b1; start_no_br = 1'($urandom); y_diag_in = WIDTH'({$urandom, $urandom});
      @(negedge clock);
      chk({tag, ".hold_valid"}, 64'(y_out_valid), 64'(1));
      chk({tag, ".hold_y"},     64'(y_out),       64'(held));
    end
    y_out_ready = 1'b1; start = 1'b1;
    @(negedge clock);
    y_out_ready = 1'b0; start = 1'b0;
    chk({tag, ".back_idle"},   64'(start_ready), 64'(1));
    chk({tag, ".valid_drop"},  64'(y_out_valid), 64'(0));
    chk({tag, ".y_kept"},      64'(y_out),       64'(ey));
  endtask

  task automatic reset_mid_node();
    int cyc;
    bit will, hit;
    start = 1'b1; start_no_br = 1'b0; y_diag_in = mk(5, 5);
    @(negedge clock);
    start = 1'b0;
    br_valid = 1'b1; br_y_old = mk(1, 2); br_y_new = mk(3, 4); br_last = 1'b0;
    hit = 1'b0; cyc = 0;
    while (!hit && cyc < 20) begin
      will = br_valid && br_ready;
      @(negedge clock);
      cyc++;
      if (will) hit = 1'b1;
    end
    chk("rst_mid.reached_sub", 64'(hit), 64'(1));
    br_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_reset_outputs("rst_mid");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_no_br = 1'b0; y_diag_in = '0;
    br_valid = 1'b0; br_y_old = '0; br_y_new = '0; br_last = 1'b0; y_out_ready = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_reset_outputs("reset");

    b_old[0] = mk(10, 5); b_new[0] = mk(30, -5); b_last[0] = 1'b1;
    run_node("one_br", mk(100, -50), 1, 0, 0);

    run_node("no_br", mk(7, 7), 0, 0, 0);

    for (int i = 0; i < 3; i++) begin
      b_old[i] = mk(1, 1); b_new[i] = mk(2, 0); b_last[i] = (i == 2);
    end
    run_node("gapped3", mk(0, 0), 3, 2, 0);

    b_old[0] = mk(0, 0); b_new[0] = mk(1, 0); b_last[0] = 1'b1;
    run_node("ovf", mk(32'h7FFFFF, 0), 1, 0, 0);
    b_old[0] = mk(3, 3); b_new[0] = mk(4, 4); b_last[0] = 1'b1;
    run_node("ovf_clear", mk(1, 1), 1, 0, 0);

    for (int i = 0; i < 9; i++) begin
      b_old[i] = mk(i, -i); b_new[i] = mk(2 * i, i); b_last[i] = 1'b0;
    end
    run_node("too_many", mk(-20, 20), 9, 0, 0);

    b_old[0] = mk(8, 8); b_new[0] = mk(-8, 9); b_last[0] = 1'b1;
    run_node("hold5", mk(50, 60), 1, 0, 5);
    reset_mid_node();

    for (int t = 0; t < 25; t++) begin
      int n;
      logic [WIDTH-1:0] diag;
      n = int'($urandom_range(0, 10));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          b_old[i] = WIDTH'({$urandom, $urandom});
          b_new[i] = WIDTH'({$urandom, $urandom});
        end else begin
          b_old[i] = mk(int'($urandom_range(0, 400)) - 200, int'($urandom_range(0, 400)) - 200);
          b_new[i] = mk(int'($urandom_range(0, 400)) - 200, int'($urandom_range(0, 400)) - 200);
        end
        b_last[i] = (i == n - 1) && (n <= int'(MAX_BR) || 1'($urandom));
      end
      diag = ($urandom_range(0, 2) == 0) ? WIDTH'({$urandom, $urandom})
                                         : mk(int'($urandom_range(0, 2000)) - 1000, 17);
      run_node("rand", diag, n, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
